serving_dispatcher: RTL
=======================

# serving_dispatcher

Downstream stage of the restaurant order/kitchen block: consumes the per-table "item ready" pulses (2-bit item code + 1-cycle strobe) and buffers them in two small per-table FIFOs. A single waiter, modelled as a state machine, carries one item at a time to its table and walks back. Arbitration between tables is round-robin. The block reports each delivery, per-table pending counts, served counts and overflow status.

## Interface
- FIFO_DEPTH, 4, entries per table FIFO (power of two, 2..8)
- TRAVEL0, 2, one-way walk time to table 0 in cycles (1..15)
- TRAVEL1, 3, one-way walk time to table 1 in cycles (1..15)

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset, asynchronous, active-high
- t0_item_ready  input  1  1-cycle strobe: table 0 item finished in kitchen
- t0_ready_item  input  2  item code, valid with t0_item_ready
- t1_item_ready  input  1  strobe for table 1
- t1_ready_item  input  2  item code for table 1
- deliver_valid  output  1  high for exactly one cycle per delivery
- deliver_table  output  1  table served (valid with deliver_valid)
- deliver_item  output  2  item code served (valid with deliver_valid)
- busy  output  1  high whenever state != IDLE
- t0_pending  output  4  table 0 FIFO occupancy (0..FIFO_DEPTH)
- t1_pending  output  4  table 1 FIFO occupancy
- t0_overflow  output  1  sticky: a table 0 item was dropped
- t1_overflow  output  1  sticky: a table 1 item was dropped
- t0_served  output  8  items delivered to table 0, saturating at 255
- t1_served  output  8  items delivered to table 1, saturating at 255

## Operation
- **Capture:** on an edge where tN_item_ready=1, push tN_ready_item into FIFO N.
  - If FIFO N is full and is not popped on the same edge, drop the item and set tN_overflow. It stays set until reset.
  - Pushes on both tables in the same edge are independent.
- **Same-edge push and pop on one FIFO:** both take effect; occupancy is unchanged. A full FIFO popped that edge accepts the push.
- **FIFO pointers:** wrap modulo FIFO_DEPTH.
- **States:** IDLE, OUT, DELIVER, BACK.
  - **IDLE:** if any FIFO is non-empty, select a table, pop its head into the carried item/table registers and go to OUT with the walk counter loaded with TRAVELn. Otherwise stay in IDLE.
  - **OUT:** lasts exactly TRAVELn cycles, then DELIVER.
  - **DELIVER:** exactly 1 cycle. deliver_valid=1 with the carried table/item; tN_served increments (saturating) on the edge leaving DELIVER.
  - **BACK:** lasts exactly TRAVELn cycles, then IDLE.
- **Round-robin arbitration:**
  - Both FIFOs non-empty: serve the table opposite to last_served.
  - One FIFO non-empty: serve that table.
  - last_served updates on the pop. It resets to 1, so table 0 wins the first tie.
- Items arriving during a trip are only queued; there is no preemption.
- deliver_table and deliver_item hold their last values outside DELIVER; they are only meaningful with deliver_valid.

## Timing
- **Reset values:** deliver_valid=0, deliver_table=0, deliver_item=0, busy=0, t0/t1_pending=0, t0/t1_overflow=0, t0/t1_served=0, state=IDLE, FIFOs empty, last_served=1.
- **Reset mid-trip:** the carried item and all queued items are discarded. No deliver_valid is emitted.
- **Capture latency:** a strobe at edge p makes pending visible after edge p. The earliest pop is at edge p+1.
- **Trip length:** with the pop at edge e, the block is in OUT for edges e..e+TRAVELn-1, DELIVER after edge e+TRAVELn, BACK for TRAVELn cycles, and IDLE after edge e+2·TRAVELn+1.
- **Back-to-back trips:** if work is pending on arrival in IDLE, the next pop happens on the first IDLE edge (1 idle cycle between trips).
- **Outputs:** all are registered; there are no combinational input-to-output paths.

## Test plan
- **Single item:** defaults; t0 strobe item 2 at edge 0.
  - pending0=1 after edge 0, 0 after edge 1.
  - deliver_valid=1, table 0, item 2 after edge 3.
  - busy falls after edge 6; t0_served=1.
- **Tie arbitration:** strobe t0 item 1 and t1 item 3 at the same edge.
  - Table 0 is served first (deliver after edge 3, IDLE after edge 6).
  - Pop t1 at edge 7; deliver table 1 item 3 after edge 10.
- **Round-robin fairness:** preload 3 items on each table.
  - Delivery order alternates T0, T1, T0, T1, T0, T1.
  - Exactly 6 deliver_valid pulses, each 1 cycle wide.
- **Overflow:** 6 consecutive t1 strobes while busy serving t0.
  - t1_pending saturates at 4; t1_overflow=1 and stays set.
  - Only the first 4 items are delivered, in FIFO order.
- **Full plus simultaneous pop:** t0 FIFO full while in IDLE, strobe on the pop edge.
  - The push is accepted; pending stays 4; no overflow.
- **Reset mid-OUT:** assert reset during OUT.
  - All outputs return to reset values immediately.
  - No deliver_valid occurs; after release the block is in IDLE with pending=0.

Source files
------------

// File: rtl/serving_dispatcher_if.sv
// rtl/serving_dispatcher_if.sv - kitchen item strobes in, waiter deliveries out
`timescale 1ns/1ps
interface serving_dispatcher_if;
    logic       t0_item_ready;
    logic [1:0] t0_ready_item;
    logic       t1_item_ready;
    logic [1:0] t1_ready_item;
    logic       deliver_valid;
    logic       deliver_table;
    logic [1:0] deliver_item;

    modport master (
        output t0_item_ready, t0_ready_item, t1_item_ready, t1_ready_item,
        input  deliver_valid, deliver_table, deliver_item
    );

    modport slave (
        input  t0_item_ready, t0_ready_item, t1_item_ready, t1_ready_item,
        output deliver_valid, deliver_table, deliver_item
    );
endinterface

// File: rtl/serving_dispatcher.sv
// rtl/serving_dispatcher.sv - two per-table item FIFOs served round-robin by one walking waiter
`timescale 1ns/1ps
module serving_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TRAVEL0    = 2,
    parameter int TRAVEL1    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    serving_dispatcher_if.slave  bus,
    output logic                 busy,
    output logic [3:0]           t0_pending,
    output logic [3:0]           t1_pending,
    output logic                 t0_overflow,
    output logic                 t1_overflow,
    output logic [7:0]           t0_served,
    output logic [7:0]           t1_served
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OUT     = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;
    localparam logic [1:0] S_BACK    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    walk_q, walk_d;
    logic          carry_table_q, carry_table_d;
    logic [1:0]    carry_item_q, carry_item_d;
    logic          last_served_q, last_served_d;
    logic          dv_q, dv_d;
    logic          dt_q, dt_d;
    logic [1:0]    di_q, di_d;
    logic [7:0]    served_q [2];
    logic [7:0]    served_d [2];
    logic          overflow_q [2];
    logic          overflow_d [2];
    logic [3:0]    count_q [2];
    logic [3:0]    count_d [2];
    logic [AW-1:0] rd_q [2];
    logic [AW-1:0] rd_d [2];
    logic [AW-1:0] wr_q [2];
    logic [AW-1:0] wr_d [2];
    logic [1:0]    mem_q [2][FIFO_DEPTH];

    logic [1:0]    push, pop, push_ok, nonempty;
    logic [1:0]    push_item [2];
    logic          pick;

    always_comb begin
        push         = {bus.t1_item_ready, bus.t0_item_ready};
        push_item[0] = bus.t0_ready_item;
        push_item[1] = bus.t1_ready_item;
        nonempty     = {(count_q[1] != 4'd0), (count_q[0] != 4'd0)};

        state_d       = state_q;
        walk_d        = walk_q;
        carry_table_d = carry_table_q;
        carry_item_d  = carry_item_q;
        last_served_d = last_served_q;
        dv_d          = 1'b0;
        dt_d          = dt_q;
        di_d          = di_q;
        pop           = 2'b00;
        pick          = 1'b0;
        served_d[0]   = served_q[0];
        served_d[1]   = served_q[1];

        case (state_q)
            S_IDLE: begin
                if (|nonempty) begin
                    // On a tie, serve the table that did not get the previous trip.
                    pick          = (&nonempty) ? ~last_served_q : ~nonempty[0];
                    pop[pick]     = 1'b1;
                    carry_table_d = pick;
                    carry_item_d  = mem_q[pick][rd_q[pick]];
                    last_served_d = pick;
                    walk_d        = pick ? 4'(TRAVEL1) : 4'(TRAVEL0);
                    state_d       = S_OUT;
                end
            end
            S_OUT: begin
                if (walk_q == 4'd1) begin
                    state_d = S_DELIVER;
                    dv_d    = 1'b1;
                    dt_d    = carry_table_q;
                    di_d    = carry_item_q;
                end else begin
                    walk_d = walk_q - 4'd1;
                end
            end
            S_DELIVER: begin
                state_d = S_BACK;
                walk_d  = carry_table_q ? 4'(TRAVEL1) : 4'(TRAVEL0);
                if (served_q[carry_table_q] != 8'hFF)
                    served_d[carry_table_q] = served_q[carry_table_q] + 8'd1;
            end
            default: begin
                if (walk_q == 4'd1)
                    state_d = S_IDLE;
                else
                    walk_d = walk_q - 4'd1;
            end
        endcase

        for (int t = 0; t < 2; t++) begin
            // A full FIFO popped this edge frees the slot the push needs.
            push_ok[t]    = push[t] && ((count_q[t] != 4'(FIFO_DEPTH)) || pop[t]);
            overflow_d[t] = overflow_q[t] | (push[t] & ~push_ok[t]);
            count_d[t]    = count_q[t] + {3'b000, push_ok[t]} - {3'b000, pop[t]};
            wr_d[t]       = push_ok[t] ? wr_q[t] + AW'(1) : wr_q[t];
            rd_d[t]       = pop[t]     ? rd_q[t] + AW'(1) : rd_q[t];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            walk_q        <= 4'd0;
            carry_table_q <= 1'b0;
            carry_item_q  <= 2'd0;
            last_served_q <= 1'b1;
            dv_q          <= 1'b0;
            dt_q          <= 1'b0;
            di_q          <= 2'd0;
            for (int t = 0; t < 2; t++) begin
                served_q[t]   <= 8'd0;
                overflow_q[t] <= 1'b0;
                count_q[t]    <= 4'd0;
                rd_q[t]       <= '0;
                wr_q[t]       <= '0;
            end
        end else begin
            state_q       <= state_d;
            walk_q        <= walk_d;
            carry_table_q <= carry_table_d;
            carry_item_q  <= carry_item_d;
            last_served_q <= last_served_d;
            dv_q          <= dv_d;
            dt_q          <= dt_d;
            di_q          <= di_d;
            for (int t = 0; t < 2; t++) begin
                served_q[t]   <= served_d[t];
                overflow_q[t] <= overflow_d[t];
                count_q[t]    <= count_d[t];
                rd_q[t]       <= rd_d[t];
                wr_q[t]       <= wr_d[t];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < 2; t++)
            if (push_ok[t])
                mem_q[t][wr_q[t]] <= push_item[t];
    end

    assign bus.deliver_valid = dv_q;
    assign bus.deliver_table = dt_q;
    assign bus.deliver_item  = di_q;
    assign busy        = (state_q != S_IDLE);
    assign t0_pending  = count_q[0];
    assign t1_pending  = count_q[1];
    assign t0_overflow = overflow_q[0];
    assign t1_overflow = overflow_q[1];
    assign t0_served   = served_q[0];
    assign t1_served   = served_q[1];
endmodule
